// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC sequencer responder: FSM states,
// CSR bit layout and the width of the response channel field.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } seq_state_e;

  localparam int   RUN_BIT      = 0;
  localparam int   MODE_BIT     = 1;
  localparam logic CSR_ADDR_SEQ = 1'b0;
  localparam int   CH_W         = 5;

endpackage

// File: rtl/adc_seq_responder_timer.sv
// Conversion timer: loadable down-counter that stops at zero and flags it.
module adc_conv_timer #(
  parameter int CONV_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CONV_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adc_seq_responder.sv
// Stand-in for the vendor ADC sequencer: CSR run/mode control, fixed-slot
// conversion sequence from sample_data, Avalon-ST-style response beats.
module adc_seq_responder
  import adc_seq_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int CONV_CYCLES = 20,
  parameter int DATA_W      = 12,
  parameter int CH_BASE     = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic [DATA_W-1:0] sample_data,
  output logic              response_valid,
  output logic [CH_W-1:0]   response_channel,
  output logic [DATA_W-1:0] response_data,
  output logic              response_startofpacket,
  output logic              response_endofpacket,
  output logic [1:0]        dbg_state
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SW-1:0]   LAST_SLOT = SW'(NUM_SLOTS - 1);
  localparam logic [CH_W-1:0] CH_BASE_W = CH_W'(CH_BASE);

  seq_state_e  state_q;
  logic        run_q, run_d;
  logic        mode_q, mode_d;
  logic [SW-1:0] slot_q;
  logic [31:0] rd_word;
  logic        wr_seq, last_slot, auto_clr;
  logic        timer_load, timer_dec, timer_zero;
  logic        unused_wdata;

  assign unused_wdata = ^csr_writedata[31:2];
  assign wr_seq       = csr_write && (csr_address == CSR_ADDR_SEQ);
  assign last_slot    = (slot_q == LAST_SLOT);
  assign auto_clr     = (state_q == ST_EMIT) && run_q && last_slot && mode_q;
  assign timer_load   = (state_q != ST_CONVERT);
  assign timer_dec    = (state_q == ST_CONVERT);
  assign dbg_state    = state_q;

  // A CSR write in the EOP cycle overrides the single-sequence auto-clear.
  always_comb begin
    rd_word           = '0;
    rd_word[RUN_BIT]  = run_q;
    rd_word[MODE_BIT] = mode_q;
    run_d             = run_q;
    mode_d            = mode_q;
    if (auto_clr) run_d = 1'b0;
    if (wr_seq) begin
      run_d  = csr_writedata[RUN_BIT];
      mode_d = csr_writedata[MODE_BIT];
    end
  end

  adc_conv_timer #(.CONV_CYCLES(CONV_CYCLES)) u_timer (
    .clk_i  (clk_in),
    .rst_i  (rst),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .zero_o (timer_zero)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q                <= ST_IDLE;
      run_q                  <= 1'b0;
      mode_q                 <= 1'b0;
      slot_q                 <= '0;
      csr_readdata           <= '0;
      response_valid         <= 1'b0;
      response_channel       <= '0;
      response_data          <= '0;
      response_startofpacket <= 1'b0;
      response_endofpacket   <= 1'b0;
    end else begin
      run_q  <= run_d;
      mode_q <= mode_d;
      if (csr_read) begin
        csr_readdata <= (csr_address == CSR_ADDR_SEQ) ? rd_word : '0;
      end
      response_valid         <= 1'b0;
      response_channel       <= '0;
      response_startofpacket <= 1'b0;
      response_endofpacket   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run_q) begin
            state_q <= ST_CONVERT;
            slot_q  <= '0;
          end
        end
        ST_CONVERT: begin
          if (!run_q) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
          end else if (timer_zero) begin
            state_q                <= ST_EMIT;
            response_valid         <= 1'b1;
            response_channel       <= CH_BASE_W + CH_W'(slot_q);
            response_data          <= sample_data;
            response_startofpacket <= (slot_q == '0);
            response_endofpacket   <= last_slot;
          end
        end
        ST_EMIT: begin
          if (!run_q) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
          end else if (!last_slot) begin
            state_q <= ST_CONVERT;
            slot_q  <= slot_q + 1'b1;
          end else begin
            slot_q  <= '0;
            state_q <= run_d ? ST_CONVERT : ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          slot_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_seq_responder.sv
// Bench for adc_seq_responder: three parameterisations share one CSR/sample
// stimulus stream and are compared against a deadline-based reference model.
module tb_adc_seq_responder;
  import adc_seq_pkg::*;

  localparam int DW = 12;
  localparam int BW = 24;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          csr_address   = 1'b0;
  logic          csr_read      = 1'b0;
  logic          csr_write     = 1'b0;
  logic [31:0]   csr_writedata = '0;
  logic [DW-1:0] sample_data   = '0;
  bit            fixed_sample  = 1'b0;

  logic [2:0]          r_valid, r_sop, r_eop;
  logic [2:0][4:0]     r_ch;
  logic [2:0][DW-1:0]  r_data;
  logic [2:0][31:0]    r_rd;
  logic [2:0][1:0]     r_dbg;

  adc_seq_responder #(.NUM_SLOTS(4), .CONV_CYCLES(20), .DATA_W(DW), .CH_BASE(1)) u_main (
    .clk_in(clk_in), .rst(rst), .csr_address(csr_address), .csr_read(csr_read),
    .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(r_rd[0]),
    .sample_data(sample_data), .response_valid(r_valid[0]), .response_channel(r_ch[0]),
    .response_data(r_data[0]), .response_startofpacket(r_sop[0]),
    .response_endofpacket(r_eop[0]), .dbg_state(r_dbg[0]));

  adc_seq_responder #(.NUM_SLOTS(1), .CONV_CYCLES(3), .DATA_W(DW), .CH_BASE(31)) u_one (
    .clk_in(clk_in), .rst(rst), .csr_address(csr_address), .csr_read(csr_read),
    .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(r_rd[1]),
    .sample_data(sample_data), .response_valid(r_valid[1]), .response_channel(r_ch[1]),
    .response_data(r_data[1]), .response_startofpacket(r_sop[1]),
    .response_endofpacket(r_eop[1]), .dbg_state(r_dbg[1]));

  adc_seq_responder #(.NUM_SLOTS(2), .CONV_CYCLES(3), .DATA_W(DW), .CH_BASE(31)) u_two (
    .clk_in(clk_in), .rst(rst), .csr_address(csr_address), .csr_read(csr_read),
    .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(r_rd[2]),
    .sample_data(sample_data), .response_valid(r_valid[2]), .response_channel(r_ch[2]),
    .response_data(r_data[2]), .response_startofpacket(r_sop[2]),
    .response_endofpacket(r_eop[2]), .dbg_state(r_dbg[2]));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] pack_beat(input int i, input logic [4:0] ch,
                                              input logic sop, input logic eop,
                                              input logic [DW-1:0] d);
    logic [1:0] id;
    id = i[1:0];
    return {id, ch, sop, eop, 3'b000, d};
  endfunction

  // Reference model: a sequence is a run of beats, each due CONV cycles
  // after the previous sequencing decision; expressed as absolute deadlines.
  int ns_p[3]   = '{4, 1, 2};
  int conv_p[3] = '{20, 3, 3};
  int chb_p[3]  = '{1, 31, 31};

  int            m_phase[3];   // 0 idle, 1 waiting for deadline, 2 beat just out
  bit            m_run[3], m_mode[3];
  int            m_slot[3], m_due[3];
  bit            e_valid[3], e_sop[3], e_eop[3];
  int            e_ch[3];
  logic [DW-1:0] e_data[3];
  logic [31:0]   e_rd[3];
  logic [BW-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_run[i] = 0; m_mode[i] = 0; m_slot[i] = 0; m_due[i] = 0;
      e_valid[i] = 0; e_sop[i] = 0; e_eop[i] = 0; e_ch[i] = 0;
      e_data[i] = '0; e_rd[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input int k);
    bit wr0, run_p, mode_p, run_n, beat;
    wr0 = csr_write && (csr_address == 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_p  = m_run[i];
      mode_p = m_mode[i];
      run_n  = wr0 ? csr_writedata[0] : run_p;
      beat   = 0;
      if (csr_read) e_rd[i] = (csr_address == 1'b0) ? {30'b0, mode_p, run_p} : 32'h0;
      e_valid[i] = 0; e_ch[i] = 0; e_sop[i] = 0; e_eop[i] = 0;
      if (m_phase[i] == 0) begin
        if (run_p) begin
          m_phase[i] = 1; m_slot[i] = 0; m_due[i] = k + conv_p[i];
        end
      end else if (!run_p) begin
        m_phase[i] = 0; m_slot[i] = 0;
      end else if (m_phase[i] == 1) begin
        if (k == m_due[i]) beat = 1;
      end else if (m_slot[i] < ns_p[i] - 1) begin
        m_slot[i]++; m_phase[i] = 1; m_due[i] = k + conv_p[i];
      end else begin
        m_slot[i] = 0;
        if (!wr0 && mode_p) run_n = 0;
        m_phase[i] = run_n ? 1 : 0;
        m_due[i] = k + conv_p[i];
      end
      if (beat) begin
        e_valid[i] = 1;
        e_ch[i]    = (chb_p[i] + m_slot[i]) % 32;
        e_data[i]  = sample_data;
        e_sop[i]   = (m_slot[i] == 0);
        e_eop[i]   = (m_slot[i] == ns_p[i] - 1);
        m_phase[i] = 2;
        exp_q.push_back(pack_beat(i, e_ch[i][4:0], e_sop[i], e_eop[i], sample_data));
      end
      m_run[i]  = run_n;
      m_mode[i] = wr0 ? csr_writedata[1] : mode_p;
    end
  endtask

  always @(posedge clk_in) begin
    if (!rst) model_step(cyc);
    cyc++;
  end

  // Beat log of the main instance plus per-instance boundary counters.
  int b_cyc[$];
  int b_ch[$];
  bit b_sop[$], b_eop[$];
  int one_total = 0, one_good = 0, two_ch0 = 0;

  always @(negedge clk_in) begin
    logic [BW-1:0] w;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_valid", i), r_valid[i], e_valid[i]);
      chk($sformatf("u%0d_data", i), r_data[i], e_data[i]);
      chk($sformatf("u%0d_readdata", i), r_rd[i], e_rd[i]);
      if (r_valid[i]) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("u%0d_unexpected_beat", i), 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk($sformatf("u%0d_beat", i), pack_beat(i, r_ch[i], r_sop[i], r_eop[i], r_data[i]), w);
        end
      end else begin
        chk($sformatf("u%0d_idle_fields", i), {r_ch[i], r_sop[i], r_eop[i]}, 0);
      end
    end
    if (r_valid[0]) begin
      b_cyc.push_back(cyc); b_ch.push_back(r_ch[0]);
      b_sop.push_back(r_sop[0]); b_eop.push_back(r_eop[0]);
    end
    if (r_valid[1]) begin
      one_total++;
      if (r_sop[1] && r_eop[1] && r_ch[1] == 5'd31) one_good++;
    end
    if (r_valid[2] && r_ch[2] == 5'd0) two_ch0++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
    sample_data = fixed_sample ? 12'hA5C : DW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic csr_wr(input logic addr, input logic [31:0] d);
    csr_address = addr; csr_writedata = d; csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic addr, output logic [31:0] v);
    csr_address = addr; csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
    v = r_rd[0];
  endtask

  task automatic wait_main_beats(input int n, input int budget);
    int start, t;
    start = b_cyc.size();
    t = 0;
    while (b_cyc.size() < start + n && t < budget) begin
      tick();
      t++;
    end
    if (b_cyc.size() < start + n) chk("wait_beats_timeout", b_cyc.size() - start, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int c0, b0, b1, pairs;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", r_valid[0], 0);
    chk("rst_readdata", r_rd[0], 0);
    chk("rst_data", r_data[0], 0);
    chk("rst_state", r_dbg[0], ST_IDLE);
    rst = 1'b0;
    idle(3);

    // Single sequence with a constant sample.
    fixed_sample = 1'b1;
    sample_data  = 12'hA5C;
    c0 = cyc;
    b0 = b_cyc.size();
    csr_wr(1'b0, 32'h3);
    wait_main_beats(4, 200);
    if (b_cyc.size() >= b0 + 4) begin
      chk("t2_first_latency", b_cyc[b0] - c0, 22);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("t2_ch%0d", j), b_ch[b0+j], j + 1);
        chk($sformatf("t2_sop%0d", j), b_sop[b0+j], j == 0);
        chk($sformatf("t2_eop%0d", j), b_eop[b0+j], j == 3);
        if (j > 0) chk($sformatf("t2_gap%0d", j), b_cyc[b0+j] - b_cyc[b0+j-1], 21);
      end
    end
    idle(40);
    csr_rd(1'b0, v);
    chk("t2_run_cleared", v, 32'h2);
    chk("t2_no_more_beats", b_cyc.size() - b0, 4);
    fixed_sample = 1'b0;

    // Held write of 3: packets run back to back.
    b0 = b_cyc.size();
    csr_address = 1'b0; csr_writedata = 32'h3; csr_write = 1'b1;
    idle(200);
    csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
    csr_write = 1'b0;
    chk("t3_run_reads_1", r_rd[0][0], 1);
    pairs = 0;
    for (int j = b0; j + 1 < b_cyc.size(); j++) begin
      if (b_eop[j] && b_sop[j+1]) begin
        pairs++;
        chk("t3_eop_to_sop", b_cyc[j+1] - b_cyc[j], 21);
      end
    end
    chk("t3_packet_pairs", pairs >= 1, 1);
    csr_wr(1'b0, 32'h0);
    idle(30);

    // Continuous run aborted during slot 2 conversion.
    b0 = b_cyc.size();
    csr_wr(1'b0, 32'h1);
    wait_main_beats(2, 100);
    idle(5);
    csr_wr(1'b0, 32'h0);
    b1 = b_cyc.size();
    idle(100);
    chk("t4_abort_no_beats", b_cyc.size() - b1, 0);
    chk("t4_beats_before_abort", b1 - b0, 2);
    b0 = b_cyc.size();
    csr_wr(1'b0, 32'h1);
    wait_main_beats(1, 60);
    if (b_cyc.size() > b0) begin
      chk("t4_restart_ch", b_ch[b0], 1);
      chk("t4_restart_sop", b_sop[b0], 1);
    end
    csr_wr(1'b0, 32'h0);
    idle(30);

    // CSR read/write addressing.
    b0 = b_cyc.size();
    csr_wr(1'b0, 32'h2);
    csr_rd(1'b0, v);
    chk("t5_read_addr0", v, 32'h2);
    csr_rd(1'b1, v);
    chk("t5_read_addr1", v, 32'h0);
    csr_wr(1'b1, 32'h1);
    idle(30);
    csr_rd(1'b0, v);
    chk("t5_addr1_write_ignored", v, 32'h2);
    chk("t5_no_beats", b_cyc.size() - b0, 0);

    // Random CSR traffic and samples.
    for (int n = 0; n < 3000; n++) begin
      csr_write     = ($urandom_range(0, 39) == 0);
      csr_address   = ($urandom_range(0, 7) == 0);
      csr_writedata = $urandom;
      csr_read      = ($urandom_range(0, 3) == 0);
      tick();
    end
    csr_write = 1'b0; csr_read = 1'b0;
    csr_wr(1'b0, 32'h0);
    idle(10);

    // Asynchronous reset in the middle of a conversion.
    csr_wr(1'b0, 32'h1);
    idle(10);
    csr_rd(1'b0, v);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t1_rst_valid", r_valid[0], 0);
    chk("t1_rst_readdata", r_rd[0], 0);
    chk("t1_rst_data", r_data[0], 0);
    chk("t1_rst_fields", {r_ch[0], r_sop[0], r_eop[0]}, 0);
    chk("t1_rst_state", r_dbg[0], ST_IDLE);
    tick();
    rst = 1'b0;
    b0 = b_cyc.size();
    idle(60);
    chk("t1_no_beat_after_rst", b_cyc.size() - b0, 0);
    chk("t1_idle_after_rst", r_dbg[0], ST_IDLE);

    chk("t6_one_beats_seen", one_total > 0, 1);
    chk("t6_one_sop_eop_ch31", one_good, one_total);
    chk("t6_two_wraps_to_ch0", two_ch0 > 0, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/adc_seq_responder.md
Name: adc_seq_responder

Overview:
Responder side of the ADC sequencer/response interface: a synthesizable stand-in for the vendor ADC IP.
- Accepts sequencer CSR reads and writes.
- Runs a fixed-slot conversion sequence from a sample input port.
- Emits Avalon-ST-style response beats (valid/channel/data/SOP/EOP).
- Lets ADC-capture logic, the RAM sink and Trojan-insertion experiments run without the hard ADC and PLL.

Parameters:
NUM_SLOTS, 4, slots per sequence (1..32)
CONV_CYCLES, 20, clk_in cycles spent in CONVERT per slot (>=1)
DATA_W, 12, sample/response data width
CH_BASE, 1, channel number reported for slot 0; slot i reports CH_BASE+i (5-bit wrap)

Ports:
clk_in  in  1  single clock
rst  in  1  asynchronous, active-high reset
csr_address  in  1  register select; only address 0 is implemented
csr_read  in  1  read strobe
csr_write  in  1  write strobe
csr_writedata  in  32  bit0 = run, bit1 = single-sequence mode, rest ignored
csr_readdata  out  32  registered read data
sample_data  in  DATA_W  value converted at the end of each CONVERT period
response_valid  out  1  one-cycle beat strobe
response_channel  out  5  channel of the beat
response_data  out  DATA_W  captured sample
response_startofpacket  out  1  asserted with the slot-0 beat
response_endofpacket  out  1  asserted with the slot NUM_SLOTS-1 beat

Behaviour:
- Reset (async, active-high): all outputs are 0; run=0, mode=0, slot=0, counter=0, state=IDLE.
- CSR write:
  - Write with address 0 loads run and mode at the clock edge.
  - Writes to address 1 are ignored.
  - Writing run=1 while already running does not restart the sequence.
- CSR read: csr_readdata = {30'b0, mode, run} one cycle after csr_read; it is 0 for address 1; it holds its value otherwise.
- States:
  - IDLE: if run=1, go to CONVERT, load counter = CONV_CYCLES-1, slot=0.
  - CONVERT: decrement the counter each cycle. When the counter is 0, capture sample_data and go to EMIT.
  - EMIT: assert response_valid for exactly 1 cycle with:
    - response_channel = CH_BASE+slot
    - response_data = captured value
    - response_startofpacket = (slot==0)
    - response_endofpacket = (slot==NUM_SLOTS-1)
  - EMIT next state:
    - If not the last slot: slot+1, reload counter, go to CONVERT.
    - If the last slot: slot=0. If mode=1, clear run and go to IDLE; else reload and go to CONVERT.
- Latency: a write setting run in cycle 0 produces the first beat in cycle CONV_CYCLES+2. Following beats are spaced CONV_CYCLES+1 cycles apart.
- No backpressure: the response has no ready signal and the sink must accept every beat.
- Stop: a write with run=0 during CONVERT or EMIT aborts the sequence. State goes to IDLE and slot to 0 on the next edge; the beat in flight still completes if EMIT is already active. No partial packet is flagged.
- Simultaneous events: a CSR write in the same cycle as the single-mode auto-clear wins. Holding csr_write=1 with writedata=3 therefore produces back-to-back sequences.
- Outputs other than the response beat fields are 0 whenever response_valid=0; response_data holds its last value.
- A mode change mid-sequence takes effect at the next EOP.
- Channel arithmetic is 5-bit unsigned and wraps modulo 32.

Decomposition:
- Package adc_seq_pkg holds:
  - the state enum (IDLE, CONVERT, EMIT)
  - CSR bit indices RUN_BIT=0 and MODE_BIT=1
  - CSR_ADDR_SEQ=0
  - the channel width of 5
- Sub-module adc_conv_timer: a loadable down-counter with a load/zero flag, width $clog2(CONV_CYCLES+1).

Test Plan:
1. Reset mid-CONVERT: assert rst asynchronously -> all outputs 0 in the same cycle; IDLE after release; no beat until a new write.
2. Single write of 3, CONV_CYCLES=20, sample_data=12'hA5C -> four beats on channels 1..4, first at cycle 22 with SOP, spacing 21 cycles, EOP on channel 4, then run reads back 0 and no further beats.
3. csr_write held high with writedata=3 -> continuous packets; SOP follows EOP after 21 cycles; run reads 1.
4. Write of 1 (continuous), then a write of 0 during slot 2 CONVERT -> no further beats, no EOP emitted, next sequence after a write of 1 starts at channel 1 with SOP.
5. CSR read at address 0 after a write of 2 -> readdata 32'h2 one cycle later; read at address 1 -> 32'h0; a write to address 1 has no effect.
6. NUM_SLOTS=1, CH_BASE=31 -> every beat has SOP=EOP=1 on channel 31; with CH_BASE=31 and NUM_SLOTS=2, the second beat is on channel 0.
